// File: rtl/conv_seq_pkg.sv
// Shared geometry, instruction-word bit map and FSM encoding for the conv sequencer.
package conv_seq_pkg;

  localparam int ROW      = 8;
  localparam int COL      = 8;
  localparam int IN_W     = 6;
  localparam int K        = 3;
  localparam int OUT_W    = IN_W - K + 1;
  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_KIJ  = K * K;
  localparam int LEN_ONIJ = OUT_W * OUT_W;
  localparam int GAP      = 10;
  localparam int W_BASE   = 1024;
  localparam int EXEC_LEN = LEN_NIJ + ROW + COL;
  localparam int AW       = 11;

  localparam int B_MODE     = 35;
  localparam int B_RELU     = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_A_P      = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_A_X      = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both memories disabled (CEN/WEN high), every strobe low.
  localparam logic [35:0] INST_IDLE = 36'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_GAP, S_W_LOAD, S_A_L0, S_EXEC, S_DRAIN,
    S_NEXT_KIJ, S_ACC_CLR, S_ACC_RD, S_RELU, S_OUT, S_DONE
  } state_t;

endpackage

// File: rtl/conv_sequencer_acc_addr_gen.sv
// Strided pmem read-address walker for the accumulate phase: one address per step,
// no multipliers; output is the address of the next read to issue.
module acc_addr_gen
  import conv_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          step_i,
  input  logic          next_i,
  output logic [AW-1:0] addr_o
);

  localparam int OJW = $clog2(OUT_W);
  localparam int KJW = $clog2(K);

  logic [AW-1:0]  base_q, base_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [OJW-1:0] oj_q, oj_d;
  logic [KJW-1:0] kj_q, kj_d;

  always_comb begin
    base_d = base_q;
    addr_d = addr_q;
    oj_d   = oj_q;
    kj_d   = kj_q;
    if (clr_i) begin
      base_d = '0;
      addr_d = '0;
      oj_d   = '0;
      kj_d   = '0;
    end else if (next_i) begin
      // Wrapping past the last output column skips the K-1 border pixels.
      if (oj_q == OJW'(OUT_W - 1)) begin
        oj_d   = '0;
        base_d = base_q + AW'(IN_W - OUT_W + 1);
      end else begin
        oj_d   = oj_q + OJW'(1);
        base_d = base_q + AW'(1);
      end
      addr_d = base_d;
      kj_d   = '0;
    end else if (step_i) begin
      // Every step moves one kij plane forward plus the kernel offset delta.
      if (kj_q == KJW'(K - 1)) begin
        kj_d   = '0;
        addr_d = addr_q + AW'(LEN_NIJ + IN_W - K + 1);
      end else begin
        kj_d   = kj_q + KJW'(1);
        addr_d = addr_q + AW'(LEN_NIJ + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      addr_q <= '0;
      oj_q   <= '0;
      kj_q   <= '0;
    end else begin
      base_q <= base_d;
      addr_q <= addr_d;
      oj_q   <= oj_d;
      kj_q   <= kj_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/conv_sequencer.sv
// Emits the WS-mode instruction stream for a full conv layer; every output is registered.
// DRAIN waits indefinitely on ofifo_valid; each pop is followed one cycle later by its pmem write.
module conv_sequencer
  import conv_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [35:0] inst,
  output logic        sfp_clr,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic        busy,
  output logic        done
);

  state_t        state_q, state_d, ret_q, ret_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [3:0]    kij_q, kij_d;
  logic [AW-1:0] wbase_q, wbase_d, pbase_q, pbase_d;
  logic [5:0]    pop_q, pop_d, n_q, n_d;
  logic          pop_vld_q, pop_vld_d;
  logic [4:0]    o_q, o_d;
  logic [35:0]   inst_q, inst_d;
  logic          sfp_clr_q, sfp_clr_d, out_valid_q, out_valid_d;
  logic [3:0]    out_idx_q, out_idx_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [5:0]    pop_base, n_base;
  logic          wr_vld;
  logic [AW-1:0] wr_addr, acc_addr;
  logic          gen_clr, gen_step, gen_next;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q + 6'd1;
    kij_d   = kij_q;
    wbase_d = wbase_q;
    pbase_d = pbase_q;
    o_d     = o_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_W_L0;
          kij_d   = '0;
          wbase_d = AW'(W_BASE);
          pbase_d = '0;
          o_d     = '0;
        end
      end
      S_W_L0:   if (cnt_q == 6'(COL - 1)) begin state_d = S_GAP; ret_d = S_W_LOAD; cnt_d = '0; end
      S_GAP:    if (cnt_q == 6'(GAP - 1)) begin state_d = ret_q; cnt_d = '0; end
      S_W_LOAD: if (cnt_q == 6'(COL - 1)) begin state_d = S_GAP; ret_d = S_A_L0; cnt_d = '0; end
      S_A_L0:   if (cnt_q == 6'(LEN_NIJ - 1)) begin state_d = S_GAP; ret_d = S_EXEC; cnt_d = '0; end
      S_EXEC:   if (cnt_q == 6'(EXEC_LEN - 1)) begin state_d = S_DRAIN; cnt_d = '0; end
      S_DRAIN:  if (n_q == 6'(LEN_NIJ)) state_d = S_NEXT_KIJ;
      S_NEXT_KIJ: begin
        kij_d   = kij_q + 4'd1;
        wbase_d = wbase_q + AW'(COL);
        pbase_d = pbase_q + AW'(LEN_NIJ);
        cnt_d   = '0;
        if (kij_q == 4'(LEN_KIJ - 1)) begin
          state_d = S_ACC_CLR;
          o_d     = '0;
        end else begin
          state_d = S_W_L0;
        end
      end
      S_ACC_CLR: begin state_d = S_ACC_RD; cnt_d = '0; end
      S_ACC_RD:  if (cnt_q == 6'(LEN_KIJ)) state_d = S_RELU;
      S_RELU:    state_d = S_OUT;
      S_OUT: begin
        o_d     = o_q + 5'd1;
        state_d = (o_q == 5'(LEN_ONIJ - 1)) ? S_DONE : S_ACC_CLR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pop counters restart on DRAIN entry; a write trails its pop by one cycle.
    pop_base  = (state_q == S_DRAIN) ? pop_q : '0;
    n_base    = (state_q == S_DRAIN) ? n_q : '0;
    pop_vld_d = (state_d == S_DRAIN) && ofifo_valid && (pop_base != 6'(LEN_NIJ));
    wr_vld    = (state_q == S_DRAIN) && pop_vld_q;
    pop_d     = pop_base + {5'b0, pop_vld_d};
    n_d       = n_base + {5'b0, wr_vld};
    wr_addr   = pbase_q + {5'b0, n_base};

    gen_clr  = (state_q == S_NEXT_KIJ);
    gen_next = (state_q == S_OUT);
    gen_step = (state_d == S_ACC_RD) && (cnt_d < 6'(LEN_KIJ));

    inst_d = INST_IDLE;
    case (state_d)
      S_W_L0: begin
        inst_d[B_CEN_X]        = 1'b0;
        inst_d[B_L0_WR]        = 1'b1;
        inst_d[B_A_X +: AW]    = wbase_d + {5'b0, cnt_d};
      end
      S_W_LOAD: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD]  = 1'b1;
      end
      S_A_L0: begin
        inst_d[B_CEN_X]     = 1'b0;
        inst_d[B_L0_WR]     = 1'b1;
        inst_d[B_A_X +: AW] = {5'b0, cnt_d};
      end
      S_EXEC: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
      end
      S_DRAIN: begin
        inst_d[B_OFIFO_RD] = pop_vld_d;
        if (wr_vld) begin
          inst_d[B_CEN_P]     = 1'b0;
          inst_d[B_WEN_P]     = 1'b0;
          inst_d[B_A_P +: AW] = wr_addr;
        end
      end
      S_ACC_RD: begin
        if (cnt_d < 6'(LEN_KIJ)) begin
          inst_d[B_CEN_P]     = 1'b0;
          inst_d[B_A_P +: AW] = acc_addr;
        end
        // pmem data arrives one cycle after its read
        inst_d[B_ACC] = (cnt_d != 6'd0);
      end
      S_RELU:  inst_d[B_RELU] = 1'b1;
      default: ;
    endcase

    sfp_clr_d   = (state_d == S_ACC_CLR);
    out_valid_d = (state_d == S_OUT);
    out_idx_d   = (state_d == S_OUT) ? o_q[3:0] : 4'd0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      cnt_q       <= '0;
      kij_q       <= '0;
      wbase_q     <= '0;
      pbase_q     <= '0;
      pop_q       <= '0;
      n_q         <= '0;
      pop_vld_q   <= 1'b0;
      o_q         <= '0;
      inst_q      <= INST_IDLE;
      sfp_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      kij_q       <= kij_d;
      wbase_q     <= wbase_d;
      pbase_q     <= pbase_d;
      pop_q       <= pop_d;
      n_q         <= n_d;
      pop_vld_q   <= pop_vld_d;
      o_q         <= o_d;
      inst_q      <= inst_d;
      sfp_clr_q   <= sfp_clr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  acc_addr_gen u_acc_addr_gen (
    .clk    (clk),
    .rst    (reset),
    .clr_i  (gen_clr),
    .step_i (gen_step),
    .next_i (gen_next),
    .addr_o (acc_addr)
  );

  assign inst      = inst_q;
  assign sfp_clr   = sfp_clr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: full runs with steady and toggling ofifo_valid, plus mid-run reset.
module tb_conv_sequencer;

  localparam logic [35:0] IDLE_W = 36'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [35:0] inst;
  logic        sfp_clr, out_valid, busy, done;
  logic [3:0]  out_idx;

  int n_checks = 0;
  int n_fail = 0;

  int cyc_busy, n_done, bad_mode, wr_no_pop, n_pop, pop_no_vld, o_cur, t;
  logic prev_rd, prev_vld;
  int l0w[$];
  int pw[$];
  int pr[$];
  int out_log[$];
  logic [15:0] rd_mask[16];
  logic [15:0] acc_mask[16];
  logic [15:0] relu_mask[16];
  logic [15:0] out_mask[16];

  conv_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .sfp_clr     (sfp_clr),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_log();
    cyc_busy = 0; n_done = 0; bad_mode = 0; wr_no_pop = 0; n_pop = 0; pop_no_vld = 0;
    o_cur = -1; t = 99; prev_rd = 1'b0; prev_vld = 1'b0;
    l0w.delete(); pw.delete(); pr.delete(); out_log.delete();
    for (int i = 0; i < 16; i++) begin
      rd_mask[i] = '0; acc_mask[i] = '0; relu_mask[i] = '0; out_mask[i] = '0;
    end
  endtask

  task automatic sample();
    logic rd;
    rd = !inst[32] && inst[31];
    if (busy) cyc_busy++;
    if (done) n_done++;
    if (inst[35] || inst[5] || inst[4]) bad_mode++;
    if (inst[2]) l0w.push_back(int'(inst[17:7]));
    if (!inst[32] && !inst[31]) begin
      pw.push_back(int'(inst[30:20]));
      if (!prev_rd) wr_no_pop++;
    end
    if (rd) pr.push_back(int'(inst[30:20]));
    if (inst[6]) begin
      n_pop++;
      if (!prev_vld) pop_no_vld++;
    end
    prev_rd = inst[6];
    prev_vld = ofifo_valid;
    if (sfp_clr) begin o_cur++; t = 0; end
    else if (t < 99) t++;
    if (o_cur >= 0 && o_cur < 16 && t < 16) begin
      if (rd)        rd_mask[o_cur][t] = 1'b1;
      if (inst[33])  acc_mask[o_cur][t] = 1'b1;
      if (inst[34])  relu_mask[o_cur][t] = 1'b1;
      if (out_valid) out_mask[o_cur][t] = 1'b1;
    end
    if (out_valid) out_log.push_back(int'(out_idx));
  endtask

  task automatic cycle(input logic st, input logic ov);
    @(posedge clk); #1;
    start = st;
    ofifo_valid = ov;
    @(negedge clk);
    sample();
  endtask

  // mode 0: ofifo_valid steady high plus a stray start; mode 1: ofifo_valid toggles.
  task automatic run_to_done(input int mode, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      cycle((mode == 0) && (i == 100), (mode == 0) ? 1'b1 : (i % 2 == 0));
      if (done) begin seen = 1'b1; break; end
    end
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  initial begin : main
    logic seen, found;
    int errs, e, oi, oj, ki, kj;

    // Reset held with start pulsing: start must be ignored.
    clear_log();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; start = 1'b1;
      @(negedge clk);
      check("rst_inst", inst, IDLE_W);
      check("rst_busy", busy, 0);
    end
    check("rst_other", {sfp_clr, out_valid, done, out_idx}, 0);
    @(posedge clk); #1; start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Run A: steady ofifo_valid.
    clear_log();
    cycle(1'b1, 1'b1);
    run_to_done(0, seen);
    check("A_done_seen", seen, 1);
    check("A_busy_cycles", cyc_busy, 1757);
    check("A_done_pulses", n_done, 1);
    check("A_mode_fifo_bits", bad_mode, 0);
    check("A_l0w_count", l0w.size(), 396);
    errs = 0;
    for (int k = 0; k < 9; k++)
      for (int i = 0; i < 44; i++) begin
        e = (i < 8) ? 1024 + 8 * k + i : i - 8;
        if (qget(l0w, k * 44 + i) != e) errs++;
      end
    check("A_l0w_errs", errs, 0);
    check("A_w_kij0_first", qget(l0w, 0), 1024);
    check("A_w_kij0_last", qget(l0w, 7), 1031);
    check("A_act_first", qget(l0w, 8), 0);
    check("A_act_last", qget(l0w, 43), 35);
    check("A_w_kij1_first", qget(l0w, 44), 1032);
    check("A_w_kij1_last", qget(l0w, 51), 1039);
    check("A_pw_count", pw.size(), 324);
    errs = 0;
    for (int i = 0; i < 324; i++) if (qget(pw, i) != i) errs++;
    check("A_pw_errs", errs, 0);
    check("A_wr_no_pop", wr_no_pop, 0);
    check("A_pops", n_pop, 324);
    check("A_pr_count", pr.size(), 144);
    errs = 0;
    for (int o = 0; o < 16; o++)
      for (int j = 0; j < 9; j++) begin
        oi = o / 4; oj = o % 4; ki = j / 3; kj = j % 3;
        e = j * 36 + (oi + ki) * 6 + (oj + kj);
        if (qget(pr, o * 9 + j) != e) errs++;
        if (o == 5) check($sformatf("A_o5_rd%0d", j), qget(pr, 45 + j), e);
      end
    check("A_pr_errs", errs, 0);
    check("A_o5_rd_mask", rd_mask[5], 16'h03FE);
    check("A_o5_acc_mask", acc_mask[5], 16'h07FC);
    check("A_o5_relu_mask", relu_mask[5], 16'h0800);
    check("A_o5_out_mask", out_mask[5], 16'h1000);
    errs = 0;
    for (int o = 0; o < 16; o++)
      if (rd_mask[o] != 16'h03FE || acc_mask[o] != 16'h07FC ||
          relu_mask[o] != 16'h0800 || out_mask[o] != 16'h1000) errs++;
    check("A_mask_errs", errs, 0);
    check("A_sfp_clr_count", o_cur + 1, 16);
    check("A_out_count", out_log.size(), 16);
    errs = 0;
    for (int i = 0; i < 16; i++) if (qget(out_log, i) != i) errs++;
    check("A_out_idx_errs", errs, 0);
    check("A_end_busy", busy, 0);
    check("A_end_inst", inst, IDLE_W);

    // Run B: ofifo_valid toggling; drain must stall exactly with it.
    clear_log();
    cycle(1'b1, 1'b0);
    run_to_done(1, seen);
    check("B_done_seen", seen, 1);
    check("B_pw_count", pw.size(), 324);
    errs = 0;
    for (int i = 0; i < 324; i++) if (qget(pw, i) != i) errs++;
    check("B_pw_errs", errs, 0);
    check("B_kij2_first", qget(pw, 72), 72);
    check("B_kij2_last", qget(pw, 107), 107);
    check("B_wr_no_pop", wr_no_pop, 0);
    check("B_pop_no_vld", pop_no_vld, 0);
    check("B_pops", n_pop, 324);
    check("B_done_pulses", n_done, 1);

    // Run C: reset during EXEC of kij=4, then restart from kij=0.
    clear_log();
    cycle(1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      cycle(1'b0, 1'b1);
      if (inst[2] && inst[17:7] == 11'd1056) found = 1'b1;
    end
    check("C_reach_kij4", found, 1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle(1'b0, 1'b1);
      if (inst[1]) found = 1'b1;
    end
    check("C_reach_exec", found, 1);
    repeat (5) cycle(1'b0, 1'b1);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check("C_abort_inst", inst, IDLE_W);
    check("C_abort_busy", busy, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    clear_log();
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1);
    check("C_restart_busy", busy, 1);
    check("C_restart_addr0", qget(l0w, 0), 1024);
    check("C_restart_addr2", qget(l0w, 2), 1026);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
